// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one N-bit ALU between two requesters. Port 0 is the CPU execute
//   stage and port 1 is the physics coprocessor. Requests are arbitrated
//   round-robin and run one at a time: IDLE (grant) -> EXEC (evaluate) ->
//   RESP (hold the result until the owning port takes it).
//
// Ports
//   clk, resetn              clock, synchronous active-low reset
//   reqX_valid/reqX_ready    request handshake, port X in {0,1}
//   reqX_A, reqX_B           operands
//   reqX_fn                  ALUfn {subtract, bool1, bool0, shft, math}
//   respX_valid/respX_ready  response handshake, port X
//   resp_R                   shared result bus (registered)
//   resp_flags               {N, C, V, Z} captured with resp_R (registered)
//   busy                     high whenever the FSM is not IDLE
//
// ALUfn decode
//   math=1          : R = A + B, or A - B when subtract=1 (wraps mod 2^N)
//   math=0, shft=1  : {bool1,bool0} 00 SLL, 01 SRL, 1x SRA, amount B[log2 N-1:0]
//   math=0, shft=0  : {bool1,bool0} 00 AND, 01 OR, 10 XOR, 11 NOR
//   C and V are the adder's carry-out and overflow for math ops and 0 for
//   logic/shift ops; N is R[N-1]; Z is set when the final R is zero.
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         resetn,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_A,
    input  logic [N-1:0] req0_B,
    input  logic [4:0]   req0_fn,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_A,
    input  logic [N-1:0] req1_B,
    input  logic [4:0]   req1_fn,

    output logic         resp0_valid,
    input  logic         resp0_ready,
    output logic         resp1_valid,
    input  logic         resp1_ready,

    output logic [N-1:0] resp_R,
    output logic [3:0]   resp_flags,
    output logic         busy
);

    localparam int SW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // ---------------------------------------------------------------- state
    state_t         r_state;
    state_t         w_next;

    logic           r_last_grant;
    logic           r_grant;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [4:0]     r_fn;
    logic [N-1:0]   r_resp_R;
    logic [3:0]     r_flags;
    logic           r_resp0_valid;
    logic           r_resp1_valid;

    logic           w_any_req;
    logic           w_grant;
    logic           w_accept;
    logic           w_resp_take;

    // ---------------------------------------------------------------- ALU
    logic [N-1:0]   w_bx;
    logic [N-1:0]   w_sum;
    logic           w_cout;
    logic           w_ovf;
    logic [SW-1:0]  w_shamt;
    logic [N-1:0]   w_alu_r;
    logic           w_alu_n;
    logic           w_alu_c;
    logic           w_alu_v;
    logic           w_alu_z;

    // ------------------------------------------------------------ grant logic
    // Round-robin: on contention the port that did not win last time wins.
    // r_last_grant resets to 1 so port 0 wins the first tie.
    always_comb begin
        w_any_req = req0_valid | req1_valid;
        if (req0_valid && req1_valid)
            w_grant = ~r_last_grant;
        else
            w_grant = req1_valid;
        w_accept    = (r_state == S_IDLE) && w_any_req;
        // Only the owning port's resp_ready matters in RESP.
        w_resp_take = r_grant ? resp1_ready : resp0_ready;
    end

    // --------------------------------------------------------- state register
    always_ff @(posedge clk) begin
        if (!resetn)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // ---------------------------------------------------------- next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req)   w_next = S_EXEC;
            S_EXEC:                   w_next = S_RESP;
            S_RESP:  if (w_resp_take) w_next = S_IDLE;
            default:                  w_next = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------- FSM outputs
    // Ready is gated by resetn so no request is accepted on a reset edge.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        busy       = (r_state != S_IDLE);
        if (r_state == S_IDLE && resetn && w_any_req) begin
            req0_ready = ~w_grant;
            req1_ready =  w_grant;
        end
    end

    // ------------------------------------------------------------ shared ALU
    // Evaluates from the operand registers only, so resp_R/resp_flags have
    // no combinational path from any input.
    always_comb begin
        w_bx            = r_fn[4] ? ~r_b : r_b;
        {w_cout, w_sum} = {1'b0, r_a} + {1'b0, w_bx} + {{N{1'b0}}, r_fn[4]};
        // Overflow: operands (after the subtract invert) agree in sign but
        // the sum does not.
        w_ovf           = (r_a[N-1] == w_bx[N-1]) && (w_sum[N-1] != r_a[N-1]);
        w_shamt         = r_b[SW-1:0];

        w_alu_r = '0;
        w_alu_c = 1'b0;
        w_alu_v = 1'b0;
        if (r_fn[0]) begin
            w_alu_r = w_sum;
            w_alu_c = w_cout;
            w_alu_v = w_ovf;
        end else if (r_fn[1]) begin
            case (r_fn[3:2])
                2'b00:   w_alu_r = r_a << w_shamt;
                2'b01:   w_alu_r = r_a >> w_shamt;
                default: w_alu_r = $unsigned($signed(r_a) >>> w_shamt);
            endcase
        end else begin
            case (r_fn[3:2])
                2'b00:   w_alu_r = r_a & r_b;
                2'b01:   w_alu_r = r_a | r_b;
                2'b10:   w_alu_r = r_a ^ r_b;
                default: w_alu_r = ~(r_a | r_b);
            endcase
        end
        w_alu_n = w_alu_r[N-1];
        w_alu_z = (w_alu_r == '0);
    end

    // --------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_last_grant  <= 1'b1;
            r_grant       <= 1'b0;
            r_a           <= '0;
            r_b           <= '0;
            r_fn          <= '0;
            r_resp_R      <= '0;
            r_flags       <= '0;
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a          <= w_grant ? req1_A  : req0_A;
                        r_b          <= w_grant ? req1_B  : req0_B;
                        r_fn         <= w_grant ? req1_fn : req0_fn;
                        r_grant      <= w_grant;
                        r_last_grant <= w_grant;
                    end
                end
                S_EXEC: begin
                    r_resp_R <= w_alu_r;
                    r_flags  <= {w_alu_n, w_alu_c, w_alu_v, w_alu_z};
                    if (r_grant)
                        r_resp1_valid <= 1'b1;
                    else
                        r_resp0_valid <= 1'b1;
                end
                S_RESP: begin
                    if (w_resp_take) begin
                        r_resp0_valid <= 1'b0;
                        r_resp1_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign resp0_valid = r_resp0_valid;
    assign resp1_valid = r_resp1_valid;
    assign resp_R      = r_resp_R;
    assign resp_flags  = r_flags;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//   Directed stimulus with hand-computed expected results. The stimulus side
//   pushes the expected {port, R, flags} into a scoreboard when a request is
//   granted; an independent monitor pops and compares on every response
//   handshake.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         resetn;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [N-1:0] req0_A, req0_B, req1_A, req1_B;
    logic [4:0]   req0_fn, req1_fn;
    logic         resp0_valid, resp1_valid;
    logic         resp0_ready, resp1_ready;
    logic [N-1:0] resp_R;
    logic [3:0]   resp_flags;
    logic         busy;

    alu_arbiter #(.N(N)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_A     (req0_A),
        .req0_B     (req0_B),
        .req0_fn    (req0_fn),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_A     (req1_A),
        .req1_B     (req1_B),
        .req1_fn    (req1_fn),
        .resp0_valid(resp0_valid),
        .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid),
        .resp1_ready(resp1_ready),
        .resp_R     (resp_R),
        .resp_flags (resp_flags),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    localparam logic [4:0] FN_ADD = 5'b00001;
    localparam logic [4:0] FN_SUB = 5'b10001;
    localparam logic [4:0] FN_AND = 5'b00000;
    localparam logic [4:0] FN_XOR = 5'b01000;
    localparam logic [4:0] FN_SLL = 5'b00010;
    localparam logic [4:0] FN_SRA = 5'b01010;

    typedef struct {
        logic         port;
        logic [N-1:0] r;
        logic [3:0]   f;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // ---------------------------------------------------------------- monitor
    always @(negedge clk) begin
        exp_t e;
        logic p;
        if (resp0_valid && resp1_valid) begin
            n_err++;
            $display("FAIL both_resp_valid: got resp0_valid=1 resp1_valid=1, want at most one");
        end
        if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) begin
            p = resp1_valid;
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_resp: port %0d R=%h flags=%b, want no response", p, resp_R, resp_flags);
            end else begin
                e = sb.pop_front();
                if (p !== e.port || resp_R !== e.r || resp_flags !== e.f) begin
                    n_err++;
                    $display("FAIL resp: got port %0d R=%h flags=%b, want port %0d R=%h flags=%b",
                             p, resp_R, resp_flags, e.port, e.r, e.f);
                end
            end
        end
    end

    // ---------------------------------------------------------------- helpers
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic port, input logic [N-1:0] r, input logic [3:0] f);
        exp_t e;
        e.port = port; e.r = r; e.f = f;
        sb.push_back(e);
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic do_reset;
        resetn = 1'b0;
        step();
        resetn = 1'b1;
    endtask

    // Bounded wait for IDLE, then realign to just after a rising edge.
    task automatic wait_idle(input string nm);
        int k = 0;
        @(negedge clk);
        while (busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (busy) begin
            n_vec++; n_err++;
            $display("FAIL %s_timeout: busy still 1 after 50 cycles, want 0", nm);
        end
        step();
    endtask

    // Single request on one port; checks handshake timing, scoreboard checks data.
    task automatic issue_one(input logic port, input logic [N-1:0] a, input logic [N-1:0] b,
                             input logic [4:0] fn, input logic [N-1:0] er, input logic [3:0] ef);
        if (port) begin req1_valid = 1; req1_A = a; req1_B = b; req1_fn = fn; end
        else      begin req0_valid = 1; req0_A = a; req0_B = b; req0_fn = fn; end
        @(negedge clk);
        chk("own_ready",   port ? req1_ready : req0_ready, 1);
        chk("other_ready", port ? req0_ready : req1_ready, 0);
        push(port, er, ef);
        step();
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        chk("exec_busy", busy, 1);
        chk("exec_no_resp", {resp1_valid, resp0_valid}, 0);
        step();
        @(negedge clk);
        chk("resp_valid", {resp1_valid, resp0_valid}, port ? 2'b10 : 2'b01);
        step();
        @(negedge clk);
        chk("back_idle", busy, 0);
        step();
    endtask

    // --------------------------------------------------------------- stimulus
    initial begin
        resetn = 0;
        req0_valid = 1; req1_valid = 0;
        req0_A = 0; req0_B = 0; req0_fn = 0;
        req1_A = 0; req1_B = 0; req1_fn = 0;
        resp0_ready = 1; resp1_ready = 1;

        // Reset state, with a request held to show ready stays low in reset.
        step(); step();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ready", {req1_ready, req0_ready}, 0);
        chk("rst_resp_valid", {resp1_valid, resp0_valid}, 0);
        chk("rst_R", resp_R, 0);
        chk("rst_flags", resp_flags, 0);
        step();
        req0_valid = 0;
        resetn = 1;
        step();

        // Single-port ALU vectors.
        issue_one(0, 32'h7FFF_FFFF, 32'h1,         FN_ADD, 32'h8000_0000, 4'b1010);
        issue_one(1, 32'h5,         32'h5,         FN_SUB, 32'h0,         4'b0101);
        issue_one(0, 32'h0,         32'h1,         FN_SUB, 32'hFFFF_FFFF, 4'b1000);
        issue_one(1, 32'hF0F0_F0F0, 32'hFF00_FF00, FN_AND, 32'hF000_F000, 4'b1000);
        issue_one(0, 32'h1234_5678, 32'h1234_5678, FN_XOR, 32'h0,         4'b0001);
        issue_one(0, 32'h1,         32'd31,        FN_SLL, 32'h8000_0000, 4'b1000);
        issue_one(1, 32'h8000_0000, 32'd4,         FN_SRA, 32'hF800_0000, 4'b1000);

        // Contention from reset: grants alternate 0,1,0,1.
        do_reset();
        req0_A = 1; req0_B = 2; req0_fn = FN_ADD;
        req1_A = 9; req1_B = 4; req1_fn = FN_SUB;
        req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < 4; i++) begin
            int k = 0;
            @(negedge clk);
            while (!(req0_ready || req1_ready) && k < 10) begin
                @(negedge clk);
                k++;
            end
            chk("rr_grant", {req1_ready, req0_ready}, (i % 2) ? 2'b10 : 2'b01);
            if (req1_ready) push(1, 32'd5, 4'b0100);
            else            push(0, 32'd3, 4'b0000);
            step();
        end
        req0_valid = 0; req1_valid = 0;
        wait_idle("rr");

        // Response backpressure plus a wrong-port ready pulse.
        resp0_ready = 0; resp1_ready = 0;
        req0_valid = 1; req1_valid = 1;
        @(negedge clk);
        chk("bp_grant0", {req1_ready, req0_ready}, 2'b01);
        push(0, 32'd3, 4'b0000);
        begin
            int k = 0;
            @(negedge clk);
            while (!resp0_valid && k < 10) begin
                @(negedge clk);
                k++;
            end
        end
        for (int c = 0; c < 10; c++) begin
            chk("bp_valid", resp0_valid, 1);
            chk("bp_R", resp_R, 32'd3);
            chk("bp_flags", resp_flags, 0);
            chk("bp_req1_ready", req1_ready, 0);
            step();
            resp1_ready = (c == 4);
            @(negedge clk);
        end
        chk("bp_wrong_port", resp0_valid, 1);
        step();
        resp1_ready = 0;
        resp0_ready = 1;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("bp_idle", busy, 0);
        chk("bp_grant1", {req1_ready, req0_ready}, 2'b10);
        push(1, 32'd5, 4'b0100);
        step();
        req0_valid = 0; req1_valid = 0;
        resp1_ready = 1;
        wait_idle("bp");

        // Reset while in EXEC discards the operation.
        req0_A = 1; req0_B = 2; req0_fn = FN_ADD;
        req0_valid = 1;
        @(negedge clk);
        chk("rx_accept", req0_ready, 1);
        step();
        req0_valid = 0;
        resetn = 0;
        step();
        resetn = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("rx_no_resp", {resp1_valid, resp0_valid}, 0);
            chk("rx_busy", busy, 0);
        end
        step();
        req0_valid = 1; req1_valid = 1;
        @(negedge clk);
        chk("rx_first_grant", {req1_ready, req0_ready}, 2'b01);
        push(0, 32'd3, 4'b0000);
        step();
        req0_valid = 0; req1_valid = 0;
        wait_idle("rx");

        // Drain scoreboard.
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        chk("sb_drain", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
